// File: rtl/ppu_regs_if.sv
// CPU-side register bus for the PPU register file ($2000-$2007).
//   address  : CPU address; the PPU decodes address[15:13] == 3'b001
//   in       : CPU write data
//   rd / we  : one-cycle read / write strobes
//   out      : registered read data, valid the cycle after rd
//   lock_cpu : high while the CPU clock-enable is withheld
// master = CPU side, slave = PPU register file.
interface ppu_regs_if;
    logic [15:0] address;
    logic [7:0]  in;
    logic        rd;
    logic        we;
    logic [7:0]  out;
    logic        lock_cpu;

    modport master (
        output address, in, rd, we,
        input  out, lock_cpu
    );

    modport slave (
        input  address, in, rd, we,
        output out, lock_cpu
    );
endinterface

// File: rtl/ppu_regs.sv
// PPU register file ($2000-$2007) and CPU-side VRAM writer.
// Owns PPUCTRL/PPUMASK, scroll, OAM address/data, the VRAM address pair v/t with
// write toggle w, the read buffer, the palette RAM, the VBlank flag and NMI. CPU
// accesses to VRAM through $2007 wait for a renderer idle slot (vram_free) while
// the CPU is stalled via lock_cpu.
// Ports:
//   clock, reset_n         : clock, asynchronous active-low reset
//   cpu                    : CPU register bus (slave side)
//   vram_free              : renderer not using VRAM this cycle
//   vram_addr/out/we       : VRAM write-side port; vram_in is read data (1-cycle latency)
//   pal_idx / pal_data     : renderer palette lookup (combinational)
//   vblank_set/vblank_clr  : VBlank start / pre-render pulses
//   nmi                    : vblank & ctrl[7]
//   ctrl, mask, scroll_x, scroll_y, oam_addr, oam_data, oam_we : register state
module ppu_regs #(
    parameter int unsigned INC_WRAP = 14
) (
    input  logic        clock,
    input  logic        reset_n,
    ppu_regs_if.slave   cpu,
    input  logic        vram_free,
    output logic [13:0] vram_addr,
    input  logic [7:0]  vram_in,
    output logic [7:0]  vram_out,
    output logic        vram_we,
    input  logic [3:0]  pal_idx,
    output logic [5:0]  pal_data,
    input  logic        vblank_set,
    input  logic        vblank_clr,
    output logic        nmi,
    output logic [7:0]  ctrl,
    output logic [7:0]  mask,
    output logic [7:0]  scroll_x,
    output logic [7:0]  scroll_y,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we
);

    typedef enum logic [2:0] {StIdle, StWait, StAcc, StRlat, StDone} state_e;

    state_e               state_q;
    logic [INC_WRAP-1:0]  v_q;
    logic [5:0]           t_hi_q;
    logic                 w_q;
    logic [7:0]           rdbuf_q;
    logic                 vblank_q;
    logic                 lock_q;
    logic [7:0]           out_q;
    logic                 op_wr_q;
    logic [13:0]          vram_addr_q;
    logic [7:0]           vram_out_q;
    logic [7:0]           ctrl_q, mask_q, scroll_x_q, scroll_y_q;
    logic [7:0]           oam_addr_q, oam_data_q;
    logic                 oam_we_q;
    logic [5:0]           pal_q [32];

    logic                 sel;
    logic [2:0]           reg_sel;
    logic                 idle_ok, wr_acc, rd_acc;
    logic [13:0]          v14;
    logic                 is_pal;
    logic [13:0]          vram_map;
    logic [4:0]           pal_wi;
    logic [INC_WRAP-1:0]  v_step, v_inc_d;
    logic                 unused_addr;

    assign sel         = (cpu.address[15:13] == 3'b001);
    assign reg_sel     = cpu.address[2:0];
    assign unused_addr = ^cpu.address[12:3];

    // The state check is redundant with lock_q in practice but keeps the
    // acceptance rule independent of how lock is sequenced.
    assign idle_ok = (state_q == StIdle) && !lock_q;
    assign wr_acc  = idle_ok && sel && cpu.we;
    assign rd_acc  = idle_ok && sel && cpu.rd && !cpu.we;

    assign v14      = 14'(v_q);
    assign is_pal   = (v14 >= 14'h3F00);
    // $3000-$3EFF mirrors the nametables at $2000-$2EFF.
    assign vram_map = (v14 >= 14'h3000) ? (v14 - 14'h1000) : v14;
    // Sprite-palette entry 0 of each group aliases the background entry.
    assign pal_wi   = (v_q[4] && (v_q[1:0] == 2'b00)) ? {1'b0, v_q[3:0]} : v_q[4:0];

    assign v_step  = ctrl_q[2] ? INC_WRAP'(32) : INC_WRAP'(1);
    assign v_inc_d = v_q + v_step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            v_q         <= '0;
            t_hi_q      <= '0;
            w_q         <= 1'b0;
            rdbuf_q     <= '0;
            vblank_q    <= 1'b0;
            lock_q      <= 1'b0;
            out_q       <= '0;
            op_wr_q     <= 1'b0;
            vram_addr_q <= '0;
            vram_out_q  <= '0;
            ctrl_q      <= '0;
            mask_q      <= '0;
            scroll_x_q  <= '0;
            scroll_y_q  <= '0;
            oam_addr_q  <= '0;
            oam_data_q  <= '0;
            oam_we_q    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                pal_q[i] <= '0;
            end
        end else begin
            // OAM address advances after the write pulse has used it; a $2003
            // write in the same cycle overrides below.
            oam_we_q <= 1'b0;
            if (oam_we_q) begin
                oam_addr_q <= oam_addr_q + 8'd1;
            end

            case (state_q)
                StIdle: begin
                    if (wr_acc) begin
                        case (reg_sel)
                            3'd0: ctrl_q <= cpu.in;
                            3'd1: mask_q <= cpu.in;
                            3'd3: oam_addr_q <= cpu.in;
                            3'd4: begin
                                oam_data_q <= cpu.in;
                                oam_we_q   <= 1'b1;
                            end
                            3'd5: begin
                                if (w_q) scroll_y_q <= cpu.in;
                                else     scroll_x_q <= cpu.in;
                                w_q <= ~w_q;
                            end
                            3'd6: begin
                                if (w_q) v_q    <= INC_WRAP'({t_hi_q, cpu.in});
                                else     t_hi_q <= cpu.in[5:0];
                                w_q <= ~w_q;
                            end
                            3'd7: begin
                                if (is_pal) begin
                                    pal_q[pal_wi] <= cpu.in[5:0];
                                    v_q           <= v_inc_d;
                                end else begin
                                    op_wr_q     <= 1'b1;
                                    vram_addr_q <= vram_map;
                                    vram_out_q  <= cpu.in;
                                    lock_q      <= 1'b1;
                                    state_q     <= StWait;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (rd_acc) begin
                        case (reg_sel)
                            3'd2: begin
                                out_q    <= {vblank_q, 7'b0};
                                vblank_q <= 1'b0;
                                w_q      <= 1'b0;
                            end
                            3'd7: begin
                                if (is_pal) begin
                                    out_q <= {2'b00, pal_q[pal_wi]};
                                    v_q   <= v_inc_d;
                                end else begin
                                    out_q       <= rdbuf_q;
                                    op_wr_q     <= 1'b0;
                                    vram_addr_q <= vram_map;
                                    lock_q      <= 1'b1;
                                    state_q     <= StWait;
                                end
                            end
                            default: out_q <= rdbuf_q;
                        endcase
                    end
                end
                StWait: begin
                    if (vram_free) state_q <= StAcc;
                end
                StAcc: begin
                    // Hold the access if the renderer reclaims the slot.
                    if (vram_free) state_q <= op_wr_q ? StDone : StRlat;
                end
                StRlat: begin
                    rdbuf_q <= vram_in;
                    state_q <= StDone;
                end
                StDone: begin
                    lock_q  <= 1'b0;
                    v_q     <= v_inc_d;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Set wins over a coincident $2002 clear and over vblank_clr.
            if (vblank_clr) vblank_q <= 1'b0;
            if (vblank_set) vblank_q <= 1'b1;
        end
    end

    assign cpu.out      = out_q;
    assign cpu.lock_cpu = lock_q;
    assign vram_addr    = vram_addr_q;
    assign vram_out     = vram_out_q;
    assign vram_we      = (state_q == StAcc) && op_wr_q && vram_free;
    assign pal_data     = pal_q[{1'b0, pal_idx}];
    assign nmi          = vblank_q & ctrl_q[7];
    assign ctrl         = ctrl_q;
    assign mask         = mask_q;
    assign scroll_x     = scroll_x_q;
    assign scroll_y     = scroll_y_q;
    assign oam_addr     = oam_addr_q;
    assign oam_data     = oam_data_q;
    assign oam_we       = oam_we_q;

endmodule
